// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters; lookup is combinational and updates land one edge later.
// There is no backpressure: a lookup is answered every cycle and an update is accepted every cycle.
module branch_target_buffer #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        predictedTaken,
  output logic [31:0] predicted_pc,
  input  logic        update_btb,
  input  logic [31:0] ex_pc,
  input  logic [31:0] jump_addr,
  input  logic        modify_pc
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             f_hit;
  logic             ex_hit;

  assign f_idx  = fetch_pc[IDX_W+1:2];
  assign f_tag  = fetch_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign predictedTaken = f_hit && ctr_q[f_idx][1];
  assign predicted_pc   = predictedTaken ? target_q[f_idx] : (fetch_pc + 32'd4);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update_btb) begin
      if (ex_hit) begin
        if (modify_pc) begin
          target_d[ex_idx] = jump_addr;
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (modify_pc) begin
        // Full replacement of whatever occupied this slot, starting weakly taken.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = jump_addr;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        predictedTaken;
  logic [31:0] predicted_pc;
  logic        update_btb;
  logic [31:0] ex_pc;
  logic [31:0] jump_addr;
  logic        modify_pc;

  int tests = 0;
  int fails = 0;

  branch_target_buffer #(.IDX_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_pc       (fetch_pc),
    .predictedTaken (predictedTaken),
    .predicted_pc   (predicted_pc),
    .update_btb     (update_btb),
    .ex_pc          (ex_pc),
    .jump_addr      (jump_addr),
    .modify_pc      (modify_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational lookup: drive fetch_pc, settle, compare both outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_pc);
    fetch_pc = pc;
    #1;
    check({tag, ".taken"}, {31'd0, predictedTaken}, {31'd0, exp_tk});
    check({tag, ".pc"}, predicted_pc, exp_pc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    update_btb = 1'b1;
    ex_pc      = pc;
    jump_addr  = tgt;
    modify_pc  = taken;
    @(posedge clk);
    #1;
    update_btb = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_pc   = 32'h0;
    update_btb = 1'b0;
    ex_pc      = 32'h0;
    jump_addr  = 32'h0;
    modify_pc  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    look("rst_lookup", 32'h1000, 1'b0, 32'h1004);
    look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    upd(32'h1000, 32'h1010, 1'b1);
    look("alloc", 32'h1000, 1'b1, 32'h1010);

    // Disabled update and non-taken miss must not touch state.
    update_btb = 1'b0; ex_pc = 32'h1000; jump_addr = 32'h5555; modify_pc = 1'b1;
    @(posedge clk); #1;
    look("upd_off", 32'h1000, 1'b1, 32'h1010);
    upd(32'h2000, 32'h6000, 1'b0);
    look("nt_miss", 32'h2000, 1'b0, 32'h2004);

    upd(32'h1000, 32'h0, 1'b0);
    look("nt1_ctr01", 32'h1000, 1'b0, 32'h1004);
    upd(32'h1000, 32'h0, 1'b0);
    look("nt2_ctr00", 32'h1000, 1'b0, 32'h1004);
    upd(32'h1000, 32'h0, 1'b0);
    upd(32'h1000, 32'h2000, 1'b1);
    look("sat_low", 32'h1000, 1'b0, 32'h1004);
    upd(32'h1000, 32'h2000, 1'b1);
    look("tk2_ctr10", 32'h1000, 1'b1, 32'h2000);

    // Same-cycle lookup sees pre-update state.
    fetch_pc = 32'h1000; update_btb = 1'b1; ex_pc = 32'h1000; jump_addr = 32'h0; modify_pc = 1'b0;
    #1;
    check("same_cycle", {31'd0, predictedTaken}, 32'd1);
    @(posedge clk); #1;
    update_btb = 1'b0;
    look("next_cycle", 32'h1000, 1'b0, 32'h1004);

    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1000, 32'h2000, 1'b1);
    upd(32'h1000, 32'h2000, 1'b1);
    look("sat_high", 32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 32'h2000, 1'b0);
    look("from_11", 32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 32'h2000, 1'b1);

    upd(32'h1040, 32'h3000, 1'b1);
    look("alias_old", 32'h1000, 1'b0, 32'h1004);
    look("alias_new", 32'h1040, 1'b1, 32'h3000);
    upd(32'h1040, 32'h7000, 1'b0);
    look("replace_ctr", 32'h1040, 1'b0, 32'h1044);

    upd(32'h2004, 32'h4001, 1'b1);
    look("bit0_tgt", 32'h2004, 1'b1, 32'h4001);
    look("pc_lsb_ign", 32'h2007, 1'b1, 32'h4001);

    // Reset between edges, with an update pending across the reset.
    update_btb = 1'b1; ex_pc = 32'h2004; jump_addr = 32'h8000; modify_pc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    look("async_rst", 32'h2004, 1'b0, 32'h2008);
    @(posedge clk); #1;
    look("rst_ign_upd", 32'h2004, 1'b0, 32'h2008);
    look("rst_wrap2", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    update_btb = 1'b0;
    look("first_upd", 32'h2004, 1'b1, 32'h8000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of the entry count (16 entries).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port fetch_pc  input  32  PC currently being fetched.
REQ-005 SHALL have port predictedTaken  output  1  fetch-side prediction; forwarded down the pipe to the execute-stage jump resolver.
REQ-006 SHALL have port predicted_pc  output  32  next fetch address.
REQ-007 SHALL have port update_btb  input  1  execute stage has resolved a control-transfer instruction this cycle.
REQ-008 SHALL have port ex_pc  input  32  PC of the resolved instruction.
REQ-009 SHALL have port jump_addr  input  32  resolved target from the execute stage.
REQ-010 SHALL have port modify_pc  input  1  resolved outcome: 1 = taken.

Function
REQ-011 SHALL hold 2**IDX_W entries, each with: valid (1 bit), tag (32-IDX_W-2 bits), target (32 bits), and a 2-bit saturating counter ctr.
REQ-012 SHALL index an entry by pc[IDX_W+1:2] and tag it with pc[31:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-013 SHALL, combinationally, raise fetch hit when valid[idx(fetch_pc)] = 1 and the stored tag equals tag(fetch_pc).
REQ-014 SHALL drive predictedTaken = hit AND ctr[idx][1].
REQ-015 SHALL drive predicted_pc = stored target when predictedTaken = 1, else fetch_pc + 4 (modulo 2^32; 0xFFFFFFFC -> 0x00000000).
REQ-016 SHALL, when update_btb = 1 and ex_pc hits, do the following at the rising clk edge:
  - Taken: ctr increments and saturates at 2'b11.
  - Not taken: ctr decrements and saturates at 2'b00.
  - Taken: target is overwritten with jump_addr.
  - Not taken: target is unchanged.
REQ-017 SHALL, when update_btb = 1, ex_pc misses and modify_pc = 1, allocate (replace) the entry at the next edge: valid = 1, tag = tag(ex_pc), target = jump_addr, ctr = 2'b10.
REQ-018 SHALL leave all state unchanged when update_btb = 1, ex_pc misses and modify_pc = 0.
REQ-019 SHALL leave all state unchanged when update_btb = 0, regardless of the other update inputs.
REQ-020 SHALL have update latency of exactly one cycle: a lookup in the cycle after the update edge sees the new state.
REQ-021 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update state to the lookup (no bypass).
REQ-022 SHALL allocate into a valid entry with a different tag by full replacement, setting ctr = 2'b10; no state from the previous occupant is retained.
REQ-023 SHALL store jump_addr verbatim, including bit 0.

Reset
REQ-024 SHALL, while rst_n = 0 (asynchronously, including mid-update), clear every entry to valid = 0, ctr = 2'b01, target = 0, tag = 0.
REQ-025 SHALL, after reset, have every lookup miss: predictedTaken = 0 and predicted_pc = fetch_pc + 4.
REQ-026 SHALL ignore update_btb while rst_n = 0; the first update takes effect at the first rising edge after rst_n deasserts.

Verification
REQ-027 SHALL be covered by a post-reset lookup: fetch_pc = 0x1000 -> predictedTaken = 0, predicted_pc = 0x1004.
REQ-028 SHALL be covered by allocation: update_btb = 1, ex_pc = 0x1000, jump_addr = 0x1010, modify_pc = 1 for one edge; then fetch_pc = 0x1000 -> predictedTaken = 1, predicted_pc = 0x1010 (ctr = 10).
REQ-029 SHALL be covered by hysteresis and saturation on entry 0x1000:
  - Two not-taken updates -> predictedTaken = 0 (ctr 00).
  - A third not-taken update -> ctr stays 00.
  - Two taken updates with jump_addr = 0x2000 -> predictedTaken = 1, predicted_pc = 0x2000.
REQ-030 SHALL be covered by aliasing: ex_pc = 0x1040 (same index as 0x1000, different tag), taken, jump_addr = 0x3000.
  - fetch_pc = 0x1000 -> miss, predicted_pc = 0x1004.
  - fetch_pc = 0x1040 -> predicted_pc = 0x3000.
REQ-031 SHALL be covered by simultaneous lookup and update: fetch_pc = ex_pc = 0x1000, not taken, ctr 10 -> same-cycle predictedTaken = 1; next cycle predictedTaken = 0.
REQ-032 SHALL be covered by reset mid-operation: assert rst_n = 0 between clock edges after REQ-028 -> predictedTaken = 0 immediately; fetch_pc = 0xFFFFFFFC -> predicted_pc = 0x00000000.
